// File: rtl/axi_llc_burst_splitter.sv
// axi_llc_burst_splitter
// Takes one AXI AW/AR transaction per handshake and emits one descriptor per
// cache line the burst touches, one per cycle, under valid/ready flow control.
// Each piece is decoded against the cached region and the SPM way range.
// Optional build macro: AXI_LLC_SPLIT_STATS_EN enables the transaction and
// descriptor counters on stat_txn_o / stat_desc_o. Otherwise both are tied to 0.
module axi_llc_burst_splitter #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned UserWidth = 4,
  parameter int unsigned LineBytes = 64,
  parameter int unsigned NumWays   = 8,
  parameter int unsigned WayBytes  = 32768,
  parameter bit          Write     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ax_valid_i,
  output logic                 ax_ready_o,
  input  logic [IdWidth-1:0]   ax_id_i,
  input  logic [AddrWidth-1:0] ax_addr_i,
  input  logic [7:0]           ax_len_i,
  input  logic [2:0]           ax_size_i,
  input  logic [1:0]           ax_burst_i,
  input  logic [UserWidth-1:0] ax_user_i,
  input  logic [AddrWidth-1:0] cached_start_i,
  input  logic [AddrWidth-1:0] cached_end_i,
  input  logic [AddrWidth-1:0] spm_start_i,
  output logic                 desc_valid_o,
  input  logic                 desc_ready_i,
  output logic [IdWidth-1:0]   desc_id_o,
  output logic [AddrWidth-1:0] desc_addr_o,
  output logic [7:0]           desc_len_o,
  output logic [2:0]           desc_size_o,
  output logic [1:0]           desc_burst_o,
  output logic [UserWidth-1:0] desc_user_o,
  output logic                 desc_last_o,
  output logic                 desc_rw_o,
  output logic                 desc_spm_o,
  output logic [NumWays-1:0]   desc_way_o,
  output logic [1:0]           desc_resp_o,
  output logic                 busy_o,
  output logic [31:0]          stat_txn_o,
  output logic [31:0]          stat_desc_o
);

  typedef logic [AddrWidth-1:0] addr_t;

  localparam int unsigned WayOffW    = $clog2(WayBytes);
  localparam addr_t       LineBytesA = addr_t'(LineBytes);
  localparam addr_t       LineMask   = LineBytesA - addr_t'(1);
  localparam addr_t       SpmBytesA  = addr_t'(NumWays) << WayOffW;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [0:0] {IDLE, SPLIT} state_e;

  state_e state_q, state_d;
  logic   accept, advance;

  // Transaction context kept across pieces (size lives in desc_size_o).
  addr_t      addr_p0;
  logic [8:0] rem_p0;
  logic [7:0] len_p0;
  logic [1:0] burst_p0;

  // Piece source: the incoming Ax in IDLE, the stored remainder in SPLIT.
  addr_t      src_addr;
  logic [8:0] src_rem;
  logic [7:0] src_len;
  logic [2:0] src_size;
  logic [1:0] src_burst;

  addr_t        line_beats, line_next, wrap_c, wrap_base, wrap_end, wrap_beats;
  addr_t        spm_off, way_idx;
  logic [8:0]   pc_beats;
  addr_t        pc_next;
  logic [1:0]   pc_burst;
  logic         pc_last, pc_spm;
  logic [NumWays-1:0] pc_way, way_dec;
  logic [1:0]   pc_resp;
  logic         in_cached, in_spm;

  // Beat count limited by an address-derived bound; result never exceeds rem.
  function automatic logic [8:0] clip_beats(input logic [8:0] rem, input addr_t lim);
    return (addr_t'(rem) < lim) ? rem : lim[8:0];
  endfunction

  // State register; an asserted reset abandons any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, handshake signals and load strobes.
  always_comb begin
    state_d      = state_q;
    ax_ready_o   = 1'b0;
    busy_o       = 1'b0;
    desc_valid_o = 1'b0;
    accept       = 1'b0;
    advance      = 1'b0;
    unique case (state_q)
      IDLE: begin
        ax_ready_o = 1'b1;
        if (ax_valid_i) begin
          accept  = 1'b1;
          state_d = SPLIT;
        end
      end
      SPLIT: begin
        busy_o       = 1'b1;
        desc_valid_o = 1'b1;
        if (desc_ready_i) begin
          if (desc_last_o) state_d = IDLE;
          else             advance = 1'b1;
        end
      end
    endcase
  end

  // Select where the next piece is cut from.
  always_comb begin
    src_addr  = addr_p0;
    src_rem   = rem_p0;
    src_len   = len_p0;
    src_size  = desc_size_o;
    src_burst = burst_p0;
    if (state_q == IDLE) begin
      src_addr  = ax_addr_i;
      src_rem   = {1'b0, ax_len_i} + 9'd1;
      src_len   = ax_len_i;
      src_size  = ax_size_i;
      src_burst = ax_burst_i;
    end
  end

  // Cut one piece: beat count, follow-on address and region decode.
  always_comb begin
    line_beats = ((LineBytesA - (src_addr & LineMask) - addr_t'(1)) >> src_size) + addr_t'(1);
    line_next  = (src_addr & ~LineMask) + LineBytesA;
    wrap_c     = (addr_t'(src_len) + addr_t'(1)) << src_size;
    wrap_base  = src_addr & ~(wrap_c - addr_t'(1));
    wrap_end   = wrap_base + wrap_c;
    wrap_beats = (wrap_end - src_addr) >> src_size;

    pc_beats = src_rem;
    pc_next  = line_next;
    pc_burst = BurstIncr;
    unique case (src_burst)
      BurstFixed: begin
        pc_burst = BurstFixed;
        pc_next  = src_addr;
      end
      BurstWrap: begin
        if (wrap_c <= LineBytesA) begin
          pc_burst = BurstWrap;
          pc_next  = src_addr;
        end else begin
          pc_beats = clip_beats(clip_beats(src_rem, line_beats), wrap_beats);
          if (src_addr + (addr_t'(pc_beats) << src_size) == wrap_end) pc_next = wrap_base;
        end
      end
      default: pc_beats = clip_beats(src_rem, line_beats);
    endcase
    pc_last = (src_rem == pc_beats);

    in_cached = (src_addr >= cached_start_i) && (src_addr < cached_end_i);
    spm_off   = src_addr - spm_start_i;
    in_spm    = (src_addr >= spm_start_i) && (spm_off < SpmBytesA);
    way_idx   = spm_off >> WayOffW;
    for (int i = 0; i < NumWays; i++) way_dec[i] = (way_idx == addr_t'(i));

    if (in_cached) begin
      pc_spm  = 1'b0;
      pc_way  = '0;
      pc_resp = RespOkay;
    end else if (in_spm) begin
      pc_spm  = 1'b1;
      pc_way  = way_dec;
      pc_resp = RespOkay;
    end else begin
      pc_spm  = 1'b1;
      pc_way  = NumWays'(1);
      pc_resp = RespSlverr;
    end
  end

  // ---- stage p0: descriptor output registers, held while stalled ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_p0      <= '0;
      rem_p0       <= '0;
      len_p0       <= '0;
      burst_p0     <= '0;
      desc_id_o    <= '0;
      desc_user_o  <= '0;
      desc_size_o  <= '0;
      desc_addr_o  <= '0;
      desc_len_o   <= '0;
      desc_burst_o <= '0;
      desc_last_o  <= 1'b0;
      desc_spm_o   <= 1'b0;
      desc_way_o   <= '0;
      desc_resp_o  <= '0;
    end else begin
      if (accept) begin
        len_p0      <= ax_len_i;
        burst_p0    <= ax_burst_i;
        desc_id_o   <= ax_id_i;
        desc_user_o <= ax_user_i;
        desc_size_o <= ax_size_i;
      end
      if (accept || advance) begin
        addr_p0      <= pc_next;
        rem_p0       <= src_rem - pc_beats;
        desc_addr_o  <= src_addr;
        desc_len_o   <= 8'(pc_beats - 9'd1);
        desc_burst_o <= pc_burst;
        desc_last_o  <= pc_last;
        desc_spm_o   <= pc_spm;
        desc_way_o   <= pc_way;
        desc_resp_o  <= pc_resp;
      end
    end
  end

  assign desc_rw_o = Write;

`ifdef AXI_LLC_SPLIT_STATS_EN
  logic [31:0] stat_txn_q, stat_desc_q;

  // Free-running handshake counters, wrapping at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_txn_q  <= '0;
      stat_desc_q <= '0;
    end else begin
      if (ax_valid_i && ax_ready_o)     stat_txn_q  <= stat_txn_q + 32'd1;
      if (desc_valid_o && desc_ready_i) stat_desc_q <= stat_desc_q + 32'd1;
    end
  end

  assign stat_txn_o  = stat_txn_q;
  assign stat_desc_o = stat_desc_q;
`else
  assign stat_txn_o  = '0;
  assign stat_desc_o = '0;
`endif

endmodule

// File: tb/tb_axi_llc_burst_splitter.sv
// Scoreboard bench for axi_llc_burst_splitter: expected descriptors are queued
// when a transaction is issued and a monitor pops them on each handshake.
module tb_axi_llc_burst_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ax_valid, ax_ready;
  logic [5:0]  ax_id;
  logic [63:0] ax_addr;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic [1:0]  ax_burst;
  logic [3:0]  ax_user;
  logic [63:0] cached_start, cached_end, spm_start;
  logic        desc_valid, desc_ready;
  logic [5:0]  desc_id;
  logic [63:0] desc_addr;
  logic [7:0]  desc_len;
  logic [2:0]  desc_size;
  logic [1:0]  desc_burst;
  logic [3:0]  desc_user;
  logic        desc_last, desc_rw, desc_spm;
  logic [7:0]  desc_way;
  logic [1:0]  desc_resp;
  logic        busy;
  logic [31:0] stat_txn, stat_desc;

  axi_llc_burst_splitter dut (
    .clk_i(clk), .rst_i(rst),
    .ax_valid_i(ax_valid), .ax_ready_o(ax_ready), .ax_id_i(ax_id), .ax_addr_i(ax_addr),
    .ax_len_i(ax_len), .ax_size_i(ax_size), .ax_burst_i(ax_burst), .ax_user_i(ax_user),
    .cached_start_i(cached_start), .cached_end_i(cached_end), .spm_start_i(spm_start),
    .desc_valid_o(desc_valid), .desc_ready_i(desc_ready), .desc_id_o(desc_id),
    .desc_addr_o(desc_addr), .desc_len_o(desc_len), .desc_size_o(desc_size),
    .desc_burst_o(desc_burst), .desc_user_o(desc_user), .desc_last_o(desc_last),
    .desc_rw_o(desc_rw), .desc_spm_o(desc_spm), .desc_way_o(desc_way),
    .desc_resp_o(desc_resp), .busy_o(busy), .stat_txn_o(stat_txn), .stat_desc_o(stat_desc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic        last;
    logic        spm;
    logic [7:0]  way;
    logic [1:0]  resp;
    logic [5:0]  id;
    logic [3:0]  user;
    logic [2:0]  size;
  } exp_t;

  exp_t    exp_q[$];
  int      n_cmp = 0;
  int      n_fail = 0;
  longint  beat_total = 0;
  logic [5:0] g_id;
  logic [3:0] g_user;
  logic [2:0] g_size;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [63:0] a, input logic [7:0] len, input logic [1:0] b,
                      input logic last, input logic spm, input logic [7:0] way,
                      input logic [1:0] resp);
    exp_t e;
    e.addr = a; e.len = len; e.burst = b; e.last = last; e.spm = spm;
    e.way = way; e.resp = resp; e.id = g_id; e.user = g_user; e.size = g_size;
    exp_q.push_back(e);
  endtask

  // Pops one expectation per descriptor handshake and compares every field.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && desc_valid && desc_ready) begin
        beat_total += longint'(desc_len) + 1;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL desc_unexpected: got addr=0x%0h len=%0d, required no descriptor",
                   desc_addr, desc_len);
        end else begin
          e = exp_q.pop_front();
          if (desc_addr !== e.addr || desc_len !== e.len || desc_burst !== e.burst ||
              desc_last !== e.last || desc_spm !== e.spm || desc_way !== e.way ||
              desc_resp !== e.resp || desc_id !== e.id || desc_user !== e.user ||
              desc_size !== e.size || desc_rw !== 1'b0) begin
            n_fail++;
            $display("FAIL desc: got addr=0x%0h len=%0d burst=%0d last=%0d spm=%0d way=%b resp=%0d id=%0d user=%0d size=%0d rw=%0d, required addr=0x%0h len=%0d burst=%0d last=%0d spm=%0d way=%b resp=%0d id=%0d user=%0d size=%0d rw=0",
                     desc_addr, desc_len, desc_burst, desc_last, desc_spm, desc_way, desc_resp,
                     desc_id, desc_user, desc_size, desc_rw,
                     e.addr, e.len, e.burst, e.last, e.spm, e.way, e.resp, e.id, e.user, e.size);
          end
        end
      end
    end
  endtask

  task automatic send_ax(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] b);
    int w = 0;
    while (!ax_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ax_ready_wait", 64'(ax_ready), 64'd1);
    ax_valid = 1'b1; ax_addr = a; ax_len = len; ax_size = sz; ax_burst = b;
    ax_id = g_id; ax_user = g_user;
    @(posedge clk); #1;
    ax_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint     bt0;
    logic [63:0] s_addr;
    logic [7:0]  s_len;

    rst = 1'b1; ax_valid = 1'b0; ax_id = '0; ax_addr = '0; ax_len = '0; ax_size = '0;
    ax_burst = '0; ax_user = '0; desc_ready = 1'b1;
    cached_start = 64'h1000_0000; cached_end = 64'h2000_0000; spm_start = 64'h2000_0000;
    g_id = 6'd5; g_user = 4'd3; g_size = 3'd3;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ax_ready", 64'(ax_ready), 64'd1);
    chk("rst_desc_valid", 64'(desc_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_desc_addr", desc_addr, 64'd0);
    chk("rst_desc_way_len", {desc_way, desc_len}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // INCR crossing two line boundaries.
    g_id = 6'd5; g_user = 4'd3; g_size = 3'd3;
    push(64'h1000_0010, 8'd5, 2'b01, 1'b0, 1'b0, 8'h00, 2'd0);
    push(64'h1000_0040, 8'd7, 2'b01, 1'b0, 1'b0, 8'h00, 2'd0);
    push(64'h1000_0080, 8'd1, 2'b01, 1'b1, 1'b0, 8'h00, 2'd0);
    send_ax(64'h1000_0010, 8'd15, 3'd3, 2'b01);
    chk("incr_busy", 64'(busy), 64'd1);
    chk("incr_valid_latency", 64'(desc_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("incr_ready_after_last", 64'(ax_ready), 64'd1);
    chk("incr_valid_after_last", 64'(desc_valid), 64'd0);
    drain("incr_drain");

    // WRAP with a 128-byte container over a 64-byte line.
    g_id = 6'd12; g_user = 4'd9;
    bt0 = beat_total;
    push(64'h1000_0030, 8'd1, 2'b01, 1'b0, 1'b0, 8'h00, 2'd0);
    push(64'h1000_0040, 8'd7, 2'b01, 1'b0, 1'b0, 8'h00, 2'd0);
    push(64'h1000_0000, 8'd5, 2'b01, 1'b1, 1'b0, 8'h00, 2'd0);
    send_ax(64'h1000_0030, 8'd15, 3'd3, 2'b10);
    drain("wrap_drain");
    chk("wrap_beat_sum", 64'(beat_total - bt0), 64'd16);

    // WRAP whose container fits within one line.
    g_id = 6'd1; g_user = 4'd0;
    push(64'h1000_0028, 8'd3, 2'b10, 1'b1, 1'b0, 8'h00, 2'd0);
    send_ax(64'h1000_0028, 8'd3, 3'd3, 2'b10);
    drain("wrap_small_drain");

    // FIXED crossing a line, held under back-pressure.
    g_id = 6'd33; g_user = 4'd15; g_size = 3'd2;
    desc_ready = 1'b0;
    push(64'h1000_003C, 8'd7, 2'b00, 1'b1, 1'b0, 8'h00, 2'd0);
    send_ax(64'h1000_003C, 8'd7, 3'd2, 2'b00);
    s_addr = desc_addr;
    s_len  = desc_len;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("fixed_stall_stable", {desc_valid, desc_last, desc_len, desc_addr[31:0]},
          {1'b1, 1'b1, s_len, s_addr[31:0]});
    end
    chk("fixed_stall_addr", desc_addr, 64'h1000_003C);
    desc_ready = 1'b1;
    drain("fixed_drain");

    // SPM way decode.
    g_id = 6'd7; g_user = 4'd2; g_size = 3'd3;
    push(64'h2001_0000, 8'd0, 2'b01, 1'b1, 1'b1, 8'b0000_0100, 2'd0);
    send_ax(64'h2001_0000, 8'd0, 3'd3, 2'b01);
    drain("spm_drain");

    // Decode error still splits at the line boundary.
    push(64'h3000_0038, 8'd0, 2'b01, 1'b0, 1'b1, 8'b0000_0001, 2'd2);
    push(64'h3000_0040, 8'd0, 2'b01, 1'b1, 1'b1, 8'b0000_0001, 2'd2);
    send_ax(64'h3000_0038, 8'd1, 3'd3, 2'b01);
    drain("slverr_drain");

    // Reset after the first piece aborts the transaction.
    g_id = 6'd5; g_user = 4'd3;
    push(64'h1000_0010, 8'd5, 2'b01, 1'b0, 1'b0, 8'h00, 2'd0);
    send_ax(64'h1000_0010, 8'd15, 3'd3, 2'b01);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(desc_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    #5 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_after_valid", 64'(desc_valid), 64'd0);
    chk("rst_after_ready", 64'(ax_ready), 64'd1);
    chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_llc_burst_splitter.md
Name: axi_llc_burst_splitter

Overview:
Sequential successor of the LLC's combinational Ax-to-descriptor cutter. It accepts one AXI AW or AR transaction per handshake and emits one descriptor per cache line touched, one per cycle, under valid/ready flow control.
- Adds correct WRAP-burst splitting and a parametrised line size and way count.
- Adds SPM way decoding against a runtime base address.
- Sits between the LLC's Ax input spill register and the descriptor distribution stage.

Parameters:
AddrWidth, 64, Ax address width in bits.
IdWidth, 6, AXI ID width.
UserWidth, 4, AXI user width (partition id), passed through.
LineBytes, 64, cache line size in bytes; power of two, 16..4096.
NumWays, 8, number of SPM ways; 1..32.
WayBytes, 32768, SPM bytes per way; power of two.
Write, 0, value driven on desc_rw_o (1 = AW channel).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
ax_valid_i  in  1  Ax valid.
ax_ready_o  out  1  Ax ready.
ax_id_i  in  IdWidth  Ax ID.
ax_addr_i  in  AddrWidth  Ax address.
ax_len_i  in  8  Ax len.
ax_size_i  in  3  Ax size.
ax_burst_i  in  2  Ax burst type.
ax_user_i  in  UserWidth  Ax user.
cached_start_i  in  AddrWidth  cached region start (inclusive).
cached_end_i  in  AddrWidth  cached region end (exclusive).
spm_start_i  in  AddrWidth  SPM base; region spans NumWays*WayBytes.
desc_valid_o  out  1  descriptor valid.
desc_ready_i  in  1  descriptor ready.
desc_id_o  out  IdWidth  descriptor ID.
desc_addr_o  out  AddrWidth  descriptor address.
desc_len_o  out  8  descriptor len.
desc_size_o  out  3  descriptor size.
desc_burst_o  out  2  descriptor burst type.
desc_user_o  out  UserWidth  descriptor user.
desc_last_o  out  1  last piece of the transaction.
desc_rw_o  out  1  equals Write.
desc_spm_o  out  1  SPM access.
desc_way_o  out  NumWays  SPM way, one-hot.
desc_resp_o  out  2  OKAY=0, SLVERR=2.
busy_o  out  1  transaction in progress.

Behaviour:
- Reset: state IDLE; ax_ready_o=1; desc_valid_o=0; busy_o=0; all desc_* registers 0.
- FSM IDLE:
  - ax_ready_o=1.
  - On ax_valid_i & ax_ready_o: register the Ax fields, set rem_beats=len+1, go to SPLIT.
  - desc_valid_o=1 from the next cycle (1-cycle latency).
- FSM SPLIT:
  - ax_ready_o=0; busy_o=1.
  - Outputs are registered and held stable while desc_valid_o & !desc_ready_i.
  - On handshake: if desc_last_o, go to IDLE (ax_ready_o=1 the next cycle, no bubble beyond that); else load the next piece into the output registers. Throughput is one descriptor per cycle.
- Piece computation, widths at AddrWidth, no truncation:
  - line_beats = ((LineBytes - addr%LineBytes - 1) >> size) + 1.
  - INCR: beats = min(rem_beats, line_beats). Next addr = line base + LineBytes.
  - FIXED: single descriptor with full len, last=1, no split.
  - WRAP: container C = (len+1)<<size; base = addr & ~(C-1).
    - If C <= LineBytes: single descriptor, burst=WRAP, full len, last=1.
    - Otherwise each piece is burst=INCR, beats = min(rem_beats, line_beats, (base+C-addr)>>size).
    - Next addr = base when the piece reaches base+C; else the next line base.
  - Per piece: desc_len_o = beats-1; rem_beats -= beats; desc_last_o = (rem_beats==beats before the update).
  - Sum of desc_len_o+1 over all pieces equals ax_len_i+1 in every case.
- Decode, evaluated per piece on the piece address:
  - In [cached_start_i, cached_end_i): spm=0, way=0, resp=OKAY.
  - Else in [spm_start_i, spm_start_i+NumWays*WayBytes): spm=1, way=1<<((addr-spm_start_i)/WayBytes), resp=OKAY.
  - Else (decode error): spm=1, way=1, resp=SLVERR. Splitting still occurs.
  - Overlapping regions: the cached region wins.
- desc_user_o and desc_id_o are copied from the Ax fields unchanged.
- Reset mid-SPLIT aborts the transaction immediately; no descriptor is emitted after reset deasserts until a new Ax handshake.
- ax_valid_i while busy is ignored; there is no input buffering.

Optional Feature:
AXI_LLC_SPLIT_STATS_EN: adds output ports stat_txn_o (32 bits, accepted transactions) and stat_desc_o (32 bits, emitted descriptors).
- Counters increment on the respective handshakes, wrap at 2^32, and reset to 0.
- Without the macro the ports still exist, are tied to 0, and no counter flops are inferred.

Test Plan:
1. INCR addr 0x1000_0010, size 3, len 15, ready=1 → 3 descriptors on consecutive cycles:
   - (0x1000_0010, len 5, last 0)
   - (0x1000_0040, len 7, last 0)
   - (0x1000_0080, len 1, last 1)
   - ax_ready_o high the cycle after the last handshake.
2. WRAP addr 0x1000_0030, size 3, len 15 → 3 INCR descriptors:
   - (0x30, len 1)
   - (0x40, len 7)
   - (0x00, len 5, last 1)
   - beat sum 16.
3. WRAP addr 0x1000_0028, size 3, len 3 → one descriptor: WRAP, addr 0x28, len 3, last 1.
4. FIXED addr 0x1000_003C, size 2, len 7 → one descriptor with len 7 and last 1, despite crossing the line; desc_* stay stable through 5 cycles of desc_ready_i=0.
5. Decode and reset:
   - spm_start_i=0x2000_0000, addr 0x2001_0000 → spm=1, way=0b0000_0100, resp OKAY.
   - Address outside both regions → SLVERR, way=0b1.
   - rst_i pulsed after the first piece of scenario 1 → desc_valid_o=0, then IDLE.
